// File: rtl/axist_to_avst_pkt_stage.sv
// AXI4-Stream to Avalon-ST packet stage: derives SOP/EOP/empty/error per beat and
// buffers through an OUT register backed by a one-entry skid so axis_tready is registered.
module axist_to_avst_pkt_stage #(
  parameter int DATA_WIDTH  = 64,
  parameter int NO_OF_BYTES = DATA_WIDTH / 8,
  parameter int EMPTY_BITS  = $clog2(NO_OF_BYTES),
  parameter int BYTE_SWAP   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   axis_tdata,
  input  logic [NO_OF_BYTES-1:0]  axis_tkeep,
  input  logic                    axis_tvalid,
  input  logic                    axis_tlast,
  output logic                    axis_tready,
  output logic [DATA_WIDTH-1:0]   avst_data,
  output logic                    avst_valid,
  output logic                    avst_sop,
  output logic                    avst_eop,
  output logic [EMPTY_BITS-1:0]   avst_empty,
  output logic                    avst_error,
  input  logic                    avst_ready,
  output logic [15:0]             pkt_count
);

  localparam logic [NO_OF_BYTES-1:0] KEEP_ALL  = {NO_OF_BYTES{1'b1}};
  localparam logic [EMPTY_BITS:0]    NB_WIDE   = (EMPTY_BITS + 1)'(NO_OF_BYTES);
  localparam logic [EMPTY_BITS-1:0]  EMPTY_MAX = EMPTY_BITS'(NO_OF_BYTES - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [EMPTY_BITS-1:0] empty;
    logic                  error;
  } beat_t;

  function automatic logic [DATA_WIDTH-1:0] map_bytes(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    if (BYTE_SWAP != 0) begin
      for (int i = 0; i < NO_OF_BYTES; i++) r[8*i +: 8] = d[8*(NO_OF_BYTES-1-i) +: 8];
    end
    return r;
  endfunction

  function automatic logic [EMPTY_BITS-1:0] calc_empty(input logic [NO_OF_BYTES-1:0] keep,
                                                       input logic last);
    logic [EMPTY_BITS:0] cnt;
    logic [EMPTY_BITS:0] diff;
    cnt = '0;
    for (int i = 0; i < NO_OF_BYTES; i++) cnt = cnt + {{EMPTY_BITS{1'b0}}, keep[i]};
    diff = NB_WIDE - cnt;
    if (!last)          return '0;
    else if (keep == '0) return EMPTY_MAX;
    else                return diff[EMPTY_BITS-1:0];
  endfunction

  // A valid last-beat keep is a run of ones from bit 0: adding one clears every set bit.
  function automatic logic keep_error(input logic [NO_OF_BYTES-1:0] keep, input logic last);
    logic [NO_OF_BYTES-1:0] inc;
    inc = keep + NO_OF_BYTES'(1);
    if (!last) return keep != KEEP_ALL;
    else       return (keep == '0) || ((keep & inc) != '0);
  endfunction

  beat_t in_beat_p0;
  beat_t skid_beat_p1;
  beat_t out_beat_p1;
  logic  skid_vld_p1;
  logic  out_vld_p1;
  logic  in_pkt;
  logic  in_fire;
  logic  out_fire;
  logic  out_load;
  logic  skid_load;
  logic  skid_vld_nxt;

  // Stage p0: beat formed from the AXI input
  always_comb begin
    in_beat_p0       = '0;
    in_beat_p0.data  = map_bytes(axis_tdata);
    in_beat_p0.sop   = ~in_pkt;
    in_beat_p0.eop   = axis_tlast;
    in_beat_p0.empty = calc_empty(axis_tkeep, axis_tlast);
    in_beat_p0.error = keep_error(axis_tkeep, axis_tlast);
  end

  assign in_fire      = axis_tvalid & axis_tready;
  assign out_fire     = out_vld_p1 & avst_ready;
  assign out_load     = ~out_vld_p1 | avst_ready;
  assign skid_load    = in_fire & (skid_vld_p1 | ~out_load);
  assign skid_vld_nxt = skid_load | (skid_vld_p1 & ~out_load);

  // Stage p1: OUT register and skid entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_p1  <= 1'b0;
      out_beat_p1 <= '0;
      skid_vld_p1 <= 1'b0;
      axis_tready <= 1'b1;
      in_pkt      <= 1'b0;
      pkt_count   <= '0;
    end else begin
      if (in_fire) in_pkt <= ~axis_tlast;
      if (out_fire && out_beat_p1.eop) pkt_count <= pkt_count + 16'd1;
      if (out_load) begin
        if (skid_vld_p1) begin
          out_vld_p1  <= 1'b1;
          out_beat_p1 <= skid_beat_p1;
        end else begin
          out_vld_p1 <= in_fire;
          if (in_fire) out_beat_p1 <= in_beat_p0;
        end
      end
      skid_vld_p1 <= skid_vld_nxt;
      axis_tready <= ~skid_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (skid_load) skid_beat_p1 <= in_beat_p0;
  end

  assign avst_valid = out_vld_p1;
  assign avst_data  = out_beat_p1.data;
  assign avst_sop   = out_beat_p1.sop;
  assign avst_eop   = out_beat_p1.eop;
  assign avst_empty = out_beat_p1.empty;
  assign avst_error = out_beat_p1.error;

endmodule
